barrier8_collector: RTL and testbench

- Upstream companion to the 8-input AND reduction. It collects eight independent 1-bit arrival requests into sticky flags.
- It presents the per-lane flags and their all-ready reduction to the downstream AND stage.
- It emits a one-cycle fire pulse when every enabled lane has arrived, then re-arms for the next round.
- A watchdog aborts an incomplete round after a programmable number of cycles.

---
 rtl/barrier8_collector.sv | 173 +++++++++++++++++
 tb/tb_barrier8_collector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/barrier8_collector.sv
// rtl/barrier8_collector.sv - eight-lane sticky arrival collector with fire pulse and watchdog
//
// Collects eight independent 1-bit arrival requests into sticky flags and
// feeds them to a downstream 8-input AND stage. When every enabled lane has
// arrived, it emits a one-cycle fire pulse and then re-arms. A watchdog
// aborts a round that stays incomplete for too long.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   req[7:0]   per-lane arrival request, bit i = lane i
//   en_mask    lane enable; a disabled lane counts as arrived and is never stored
//   clear      synchronous abort of the current round (no pulse)
//   flags      registered sticky arrival flags, already masked by en_mask
//   all_ready  &(flags | ~en_mask), using the live en_mask
//   fire       one-cycle completion pulse
//   timeout    one-cycle watchdog-abort pulse
//   busy       high while a round is in progress or a pulse is out
//   count      popcount of flags, 0..8

module barrier8_collector #(
  parameter int unsigned UUID           = 0,
  parameter              NAME           = "",
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] en_mask,
  input  logic       clear,
  output logic [7:0] flags,
  output logic       all_ready,
  output logic       fire,
  output logic       timeout,
  output logic       busy,
  output logic [3:0] count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FIRE    = 2'd2,
    ST_ABORT   = 2'd3
  } state_t;

  // A zero TIMEOUT_CYCLES turns the watchdog off entirely; TIMER_LAST is
  // only consulted when the watchdog is on, so its wrapped value is harmless.
  localparam bit          WATCHDOG_ON = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] TIMER_MAX   = 16'hFFFF;
  localparam int          NAME_BITS   = $bits(NAME);

  // Identification parameters carry no logic; they are folded here only so
  // that they are referenced.
  logic [31:0] w_unused_ids;
  assign w_unused_ids = UUID ^ NAME_BITS;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_flags;
  logic [7:0]  w_flags_nxt;
  logic [15:0] r_timer;
  logic [15:0] w_timer_nxt;
  logic        r_fire;
  logic        w_fire_nxt;
  logic        r_timeout;
  logic        w_timeout_nxt;

  logic [7:0]  w_req_en;
  logic [7:0]  w_nf;
  logic [7:0]  w_nf_masked;
  logic        w_done;
  logic [3:0]  w_count;

  // Candidate flags for this edge. Masking the stored value as well drops
  // any lane that was disabled since the last edge.
  assign w_req_en    = req & en_mask;
  assign w_nf        = r_flags | w_req_en;
  assign w_nf_masked = w_nf & en_mask;

  // With an all-zero mask the reduction would be trivially true; such a
  // round must never fire.
  assign w_done = (&(w_nf | ~en_mask)) && (en_mask != 8'h00);

  always_comb begin
    w_state_nxt   = r_state;
    w_flags_nxt   = r_flags;
    w_timer_nxt   = r_timer;
    w_fire_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;

    if (clear) begin
      // Requests presented with clear are discarded.
      w_state_nxt = ST_IDLE;
      w_flags_nxt = 8'h00;
      w_timer_nxt = 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_flags_nxt = 8'h00;
          w_timer_nxt = 16'h0000;
          if (w_done) begin
            // All enabled lanes arrived together: skip COLLECT.
            w_state_nxt = ST_FIRE;
            w_flags_nxt = w_nf_masked;
            w_fire_nxt  = 1'b1;
          end else if (w_req_en != 8'h00) begin
            w_state_nxt = ST_COLLECT;
            w_flags_nxt = w_nf_masked;
          end
        end

        ST_COLLECT: begin
          w_flags_nxt = w_nf_masked;
          if (w_done) begin
            // Completion beats a watchdog expiring on the same edge.
            w_state_nxt = ST_FIRE;
            w_fire_nxt  = 1'b1;
          end else if (WATCHDOG_ON && (r_timer == TIMER_LAST)) begin
            w_state_nxt   = ST_ABORT;
            w_timeout_nxt = 1'b1;
          end else if (r_timer != TIMER_MAX) begin
            w_timer_nxt = r_timer + 16'd1;
          end
        end

        ST_FIRE, ST_ABORT: begin
          // Pulse cycle: flags are held for the observer, req is ignored.
          w_state_nxt = ST_IDLE;
          w_flags_nxt = 8'h00;
          w_timer_nxt = 16'h0000;
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_flags_nxt = 8'h00;
          w_timer_nxt = 16'h0000;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_flags   <= 8'h00;
      r_timer   <= 16'h0000;
      r_fire    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_flags   <= w_flags_nxt;
      r_timer   <= w_timer_nxt;
      r_fire    <= w_fire_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_count = w_count + {3'b000, r_flags[i]};
    end
  end

  assign flags     = r_flags;
  assign all_ready = &(r_flags | ~en_mask);
  assign fire      = r_fire;
  assign timeout   = r_timeout;
  assign busy      = (r_state != ST_IDLE);
  assign count     = w_count;

endmodule

// File: tb/tb_barrier8_collector.sv
// tb/tb_barrier8_collector.sv - scoreboard bench for barrier8_collector

module tb_barrier8_collector;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       clear;
  logic [7:0] req;
  logic [7:0] en_mask;

  logic [7:0] flags4, flags0;
  logic       all_ready4, all_ready0;
  logic       fire4, fire0;
  logic       timeout4, timeout0;
  logic       busy4, busy0;
  logic [3:0] count4, count0;

  barrier8_collector #(.UUID(1), .NAME("wd4"), .TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .en_mask(en_mask), .clear(clear),
    .flags(flags4), .all_ready(all_ready4), .fire(fire4), .timeout(timeout4),
    .busy(busy4), .count(count4)
  );

  barrier8_collector #(.UUID(2), .NAME("wd0"), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .en_mask(en_mask), .clear(clear),
    .flags(flags0), .all_ready(all_ready0), .fire(fire0), .timeout(timeout0),
    .busy(busy0), .count(count0)
  );

  typedef struct packed {
    logic [7:0] flags;
    logic       all_ready;
    logic       fire;
    logic       timeout;
    logic       busy;
    logic [3:0] count;
  } obs_t;

  obs_t exp_q4[$];
  obs_t exp_q0[$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: per instance, the set of lanes seen so far this round,
  // whether a round is open, its age in cycles, and any pulse being shown.
  bit [7:0] m_arr   [2];
  bit       m_open  [2];
  int       m_age   [2];
  int       m_pulse [2];   // 0 none, 1 fire, 2 timeout
  int       m_limit [2] = '{4, 0};

  task automatic model_step(input int k, input bit r, input bit c,
                            input bit [7:0] rq, input bit [7:0] mk);
    bit [7:0] seen;
    bit       complete;
    if (!r || c) begin
      m_arr[k] = 8'h00; m_open[k] = 1'b0; m_age[k] = 0; m_pulse[k] = 0;
    end else if (m_pulse[k] != 0) begin
      m_arr[k] = 8'h00; m_open[k] = 1'b0; m_age[k] = 0; m_pulse[k] = 0;
    end else begin
      seen     = (m_arr[k] | (rq & mk)) & mk;
      complete = (mk != 8'h00) && ((seen | ~mk) == 8'hFF);
      m_arr[k] = seen;
      if (complete) begin
        m_pulse[k] = 1; m_open[k] = 1'b0;
      end else if (m_open[k]) begin
        if (m_limit[k] != 0 && m_age[k] == m_limit[k] - 1) begin
          m_pulse[k] = 2; m_open[k] = 1'b0;
        end else if (m_age[k] < 65535) begin
          m_age[k] = m_age[k] + 1;
        end
      end else if (seen != 8'h00) begin
        m_open[k] = 1'b1; m_age[k] = 0;
      end
    end
  endtask

  function automatic obs_t model_out(input int k, input bit [7:0] mk);
    obs_t o;
    o.flags     = m_arr[k];
    o.all_ready = ((m_arr[k] | ~mk) == 8'hFF);
    o.fire      = (m_pulse[k] == 1);
    o.timeout   = (m_pulse[k] == 2);
    o.busy      = m_open[k] || (m_pulse[k] != 0);
    o.count     = 4'($countones(m_arr[k]));
    return o;
  endfunction

  // Drive one cycle of stimulus, predict the outputs after the coming edge,
  // then wait for the falling edge before the next drive.
  task automatic cyc(input bit r, input bit c, input bit [7:0] rq, input bit [7:0] mk);
    rst = r; clear = c; req = rq; en_mask = mk;
    model_step(0, r, c, rq, mk);
    model_step(1, r, c, rq, mk);
    exp_q4.push_back(model_out(0, mk));
    exp_q0.push_back(model_out(1, mk));
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, want);
    end
  endtask

  task automatic compare(input string tag, input obs_t got, input obs_t want);
    chk({tag, ".flags"},     32'(got.flags),     32'(want.flags));
    chk({tag, ".all_ready"}, 32'(got.all_ready), 32'(want.all_ready));
    chk({tag, ".fire"},      32'(got.fire),      32'(want.fire));
    chk({tag, ".timeout"},   32'(got.timeout),   32'(want.timeout));
    chk({tag, ".busy"},      32'(got.busy),      32'(want.busy));
    chk({tag, ".count"},     32'(got.count),     32'(want.count));
  endtask

  // Monitor: samples shortly after each rising edge, independent of stimulus.
  initial begin
    obs_t e;
    obs_t g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q4.size() > 0) begin
        e = exp_q4.pop_front();
        g = '{flags4, all_ready4, fire4, timeout4, busy4, count4};
        compare("t4", g, e);
      end
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        g = '{flags0, all_ready0, fire0, timeout0, busy0, count0};
        compare("t0", g, e);
      end
    end
  end

  initial begin
    bit         r;
    bit         c;
    bit [7:0]   rq;
    bit [7:0]   mk;

    // Reset state
    cyc(0, 0, 8'hFF, 8'hFF);
    cyc(0, 0, 8'h00, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);

    // Reset mid-round, then all lanes at once
    cyc(1, 0, 8'h0F, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);
    cyc(0, 0, 8'h30, 8'hFF);
    cyc(1, 0, 8'hFF, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);

    // Staggered single-lane arrivals
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'(1 << i), 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);

    // Masked lanes are ignored, enabled lanes complete the round
    cyc(1, 0, 8'hF0, 8'h0F);
    cyc(1, 0, 8'hF0, 8'h0F);
    cyc(1, 0, 8'h0F, 8'h0F);
    cyc(1, 0, 8'h00, 8'h0F);
    cyc(1, 0, 8'h00, 8'h0F);

    // All-zero mask never fires
    cyc(1, 0, 8'hFF, 8'h00);
    cyc(1, 0, 8'hFF, 8'h00);

    // Watchdog: one instance aborts, the disabled one keeps collecting
    cyc(1, 0, 8'h03, 8'hFF);
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'h00, 8'hFF);
    for (int i = 0; i < 1000; i++) cyc(1, 0, 8'h00, 8'hFF);
    cyc(1, 1, 8'h00, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);

    // Last lane lands on the edge the watchdog would expire
    cyc(1, 0, 8'h7F, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);
    cyc(1, 0, 8'h80, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);

    // clear discards same-cycle requests, from idle and mid-round
    cyc(1, 1, 8'hFF, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);
    cyc(1, 0, 8'h11, 8'hFF);
    cyc(1, 1, 8'hEE, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);

    // Requests held through the pulse cycle are not latched
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'hFF, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);

    // Mask change alone completes a round
    cyc(1, 0, 8'h0F, 8'hFF);
    cyc(1, 0, 8'h00, 8'h0F);
    cyc(1, 0, 8'h00, 8'h0F);
    // Newly enabled lanes start un-arrived
    cyc(1, 0, 8'h01, 8'h0F);
    cyc(1, 0, 8'h00, 8'hFF);
    cyc(1, 0, 8'h0E, 8'hFF);
    cyc(1, 0, 8'hF0, 8'hFF);
    cyc(1, 0, 8'h00, 8'hFF);

    // Randomized traffic
    mk = 8'hFF;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 299) != 0);
      c  = ($urandom_range(0, 149) == 0);
      rq = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 3))
          0:       mk = 8'hFF;
          1:       mk = 8'h00;
          default: mk = 8'($urandom);
        endcase
      end
      cyc(r, c, rq, mk);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && (exp_q4.size() + exp_q0.size()) != 0; i++) @(negedge clk);
    chk("drain", 32'(exp_q4.size() + exp_q0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
